// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the load-use / control hazard stall unit.
package hazard_stall_unit_pkg;

  typedef enum logic [1:0] {HZ_RUN, HZ_LD_STALL, HZ_FLUSH} hz_state_t;

  localparam logic [4:0] XZR   = 5'd31;
  localparam int         REM_W = 4;

  // A source field only counts when the ID instruction actually reads it.
  function automatic logic src_match(input logic use_f, input logic [4:0] fld,
                                     input logic [4:0] rd_ex);
    return use_f && (fld == rd_ex);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID/EX-side hazard signals and pipeline-control outputs of the stall unit.
interface hazard_stall_unit_if #(parameter int CNT_W = 16);

  logic             MemReadEx;
  logic [4:0]       RdEx;
  logic [4:0]       Rn;
  logic [4:0]       Rm;
  logic [4:0]       Rd;
  logic             UseRn;
  logic             UseRm;
  logic             UseRd;
  logic             BrTaken;
  logic             CntClear;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             BubbleEx;
  logic             FlushIFID;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output MemReadEx, RdEx, Rn, Rm, Rd, UseRn, UseRm, UseRd, BrTaken, CntClear,
    input  PCWrite, IFIDWrite, BubbleEx, FlushIFID, StallCnt, FlushCnt
  );

  modport slave (
    input  MemReadEx, RdEx, Rn, Rm, Rd, UseRn, UseRm, UseRd, BrTaken, CntClear,
    output PCWrite, IFIDWrite, BubbleEx, FlushIFID, StallCnt, FlushCnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use and taken-branch hazard control: Mealy stall/flush outputs plus
// saturating performance counters.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int LOAD_STALLS  = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_unit_if.slave  hz
);

  localparam logic [REM_W-1:0] LD_REM = REM_W'(LOAD_STALLS - 1);
  localparam logic [REM_W-1:0] FL_REM = REM_W'(FLUSH_CYCLES - 1);

  hz_state_t        state, state_n;
  logic [REM_W-1:0] rem, rem_n;
  logic             ld_haz;
  logic             pc_write, ifid_write, bubble, flush;

  assign ld_haz = hz.MemReadEx && (hz.RdEx != XZR) &&
                  (src_match(hz.UseRn, hz.Rn, hz.RdEx) ||
                   src_match(hz.UseRm, hz.Rm, hz.RdEx) ||
                   src_match(hz.UseRd, hz.Rd, hz.RdEx));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HZ_RUN;
      rem   <= '0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
    end
  end

  // Reset also gates the Mealy outputs so a live hazard cannot leak through while held in reset.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    state_n    = state;
    rem_n      = rem;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    bubble     = 1'b0;
    flush      = 1'b0;
    if (!reset) begin
      unique case (state)
        HZ_RUN: begin
          if (ld_haz) begin
            // Load stall wins; a simultaneous branch resolved on a stale operand is masked.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble     = 1'b1;
            if (LOAD_STALLS > 1) begin
              state_n = HZ_LD_STALL;
              rem_n   = LD_REM;
            end
          end else if (hz.BrTaken) begin
            flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_n = HZ_FLUSH;
              rem_n   = FL_REM;
            end
          end
        end
        HZ_LD_STALL: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          bubble     = 1'b1;
          rem_n      = rem - REM_W'(1);
          if (rem <= REM_W'(1)) begin
            state_n = HZ_RUN;
          end
        end
        HZ_FLUSH: begin
          // Any branch seen here is on the wrong path and is ignored.
          flush = 1'b1;
          rem_n = rem - REM_W'(1);
          if (rem <= REM_W'(1)) begin
            state_n = HZ_RUN;
          end
        end
        default: begin
          state_n = HZ_RUN;
          rem_n   = '0;
        end
      endcase
    end
  end

  assign hz.PCWrite   = pc_write;
  assign hz.IFIDWrite = ifid_write;
  assign hz.BubbleEx  = bubble;
  assign hz.FlushIFID = flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (hz.CntClear),
    .inc   (bubble),
    .cnt   (hz.StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (hz.CntClear),
    .inc   (flush),
    .cnt   (hz.FlushCnt)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: dut_a (1/1 cycles, 2-bit counters), dut_b (3/2 cycles, 16-bit counters).
module tb_hazard_stall_unit;

  typedef struct {
    string      name;
    logic       mem_read;
    logic [4:0] rd_ex, rn, rm, rd;
    logic       use_rn, use_rm, use_rd, br, clr;
    logic [3:0] exp;  // {PCWrite, IFIDWrite, BubbleEx, FlushIFID}
  } vec_t;

  typedef struct {
    string      name;
    bit         sel_b;
    logic [3:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  sb_t  sb_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  hazard_stall_unit_if #(.CNT_W(2))  ifa ();
  hazard_stall_unit_if #(.CNT_W(16)) ifb ();

  hazard_stall_unit #(.LOAD_STALLS(1), .FLUSH_CYCLES(1), .CNT_W(2)) dut_a (
    .clk (clk), .reset (reset), .hz (ifa.slave)
  );

  hazard_stall_unit #(.LOAD_STALLS(3), .FLUSH_CYCLES(2), .CNT_W(16)) dut_b (
    .clk (clk), .reset (reset), .hz (ifb.slave)
  );

  function automatic vec_t mk(input string name, input logic mem_read, input logic [4:0] rd_ex,
                              input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                              input logic use_rn, input logic use_rm, input logic use_rd,
                              input logic br, input logic clr, input logic [3:0] exp);
    vec_t v;
    v.name = name; v.mem_read = mem_read; v.rd_ex = rd_ex; v.rn = rn; v.rm = rm; v.rd = rd;
    v.use_rn = use_rn; v.use_rm = use_rm; v.use_rd = use_rd; v.br = br; v.clr = clr; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input bit sel_b);
    ifa.MemReadEx = 1'b0; ifa.RdEx = '0; ifa.Rn = '0; ifa.Rm = '0; ifa.Rd = '0;
    ifa.UseRn = 1'b0; ifa.UseRm = 1'b0; ifa.UseRd = 1'b0; ifa.BrTaken = 1'b0; ifa.CntClear = 1'b0;
    ifb.MemReadEx = 1'b0; ifb.RdEx = '0; ifb.Rn = '0; ifb.Rm = '0; ifb.Rd = '0;
    ifb.UseRn = 1'b0; ifb.UseRm = 1'b0; ifb.UseRd = 1'b0; ifb.BrTaken = 1'b0; ifb.CntClear = 1'b0;
    if (sel_b) begin
      ifb.MemReadEx = v.mem_read; ifb.RdEx = v.rd_ex; ifb.Rn = v.rn; ifb.Rm = v.rm; ifb.Rd = v.rd;
      ifb.UseRn = v.use_rn; ifb.UseRm = v.use_rm; ifb.UseRd = v.use_rd;
      ifb.BrTaken = v.br; ifb.CntClear = v.clr;
    end else begin
      ifa.MemReadEx = v.mem_read; ifa.RdEx = v.rd_ex; ifa.Rn = v.rn; ifa.Rm = v.rm; ifa.Rd = v.rd;
      ifa.UseRn = v.use_rn; ifa.UseRm = v.use_rm; ifa.UseRd = v.use_rd;
      ifa.BrTaken = v.br; ifa.CntClear = v.clr;
    end
  endtask

  function automatic logic [3:0] outs(input bit sel_b);
    if (sel_b) return {ifb.PCWrite, ifb.IFIDWrite, ifb.BubbleEx, ifb.FlushIFID};
    return {ifa.PCWrite, ifa.IFIDWrite, ifa.BubbleEx, ifa.FlushIFID};
  endfunction

  // One pipeline cycle: drive after the edge, queue the expectation, compare mid-cycle.
  task automatic step(input vec_t v, input bit sel_b);
    sb_t e;
    @(posedge clk);
    #1;
    drive(v, sel_b);
    sb_q.push_back('{name: v.name, sel_b: sel_b, exp: v.exp});
    @(negedge clk);
    e = sb_q.pop_front();
    check(e.name, 32'(outs(e.sel_b)), 32'(e.exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle, haz2;
    idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100);
    haz2 = mk("haz2", 1, 2, 2, 0, 0, 1, 0, 0, 1, 0, 4'b0010);

    // Reset with a live hazard and branch on both inputs: outputs must still be at reset values.
    reset = 1'b1;
    drive(haz2, 1'b0);
    ifb.MemReadEx = 1'b1; ifb.RdEx = 5'd2; ifb.Rn = 5'd2; ifb.UseRn = 1'b1; ifb.BrTaken = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_a", 32'(outs(1'b0)), 32'hC);
    check("rst_out_b", 32'(outs(1'b1)), 32'hC);
    check("rst_cnt_a", {28'd0, ifa.StallCnt, ifa.FlushCnt}, 32'd0);
    check("rst_cnt_b", {ifb.StallCnt, ifb.FlushCnt}, 32'd0);
    drive(idle, 1'b0);
    reset = 1'b0;

    // Single-cycle load-use on Rn.
    step(mk("t1_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100), 1'b0);
    step(mk("t1_ldur", 1, 2, 2, 0, 0, 1, 0, 0, 0, 0, 4'b0010), 1'b0);
    step(mk("t1_after", 0, 2, 2, 0, 0, 1, 0, 0, 0, 0, 4'b1100), 1'b0);
    check("t1_stallcnt", 32'(ifa.StallCnt), 32'd1);

    tbl.push_back(mk("xzr",       1, 31, 31, 0, 0, 1, 0, 0, 0, 0, 4'b1100));
    tbl.push_back(mk("rm_unused", 1,  7,  0, 7, 0, 0, 0, 0, 0, 0, 4'b1100));
    tbl.push_back(mk("rm_used",   1,  7,  0, 7, 0, 0, 1, 0, 0, 0, 4'b0010));
    tbl.push_back(mk("rd_src",    1,  5,  0, 0, 5, 0, 0, 1, 0, 0, 4'b0010));
    tbl.push_back(mk("no_load",   0,  5,  0, 0, 5, 0, 0, 1, 0, 0, 4'b1100));
    tbl.push_back(mk("multi",     1,  9,  1, 9, 0, 1, 1, 0, 0, 0, 4'b0010));
    tbl.push_back(mk("rn_unused", 1,  3,  3, 4, 0, 0, 1, 0, 0, 0, 4'b1100));
    tbl.push_back(mk("branch",    0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 4'b1101));
    tbl.push_back(mk("after_br",  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 4'b1100));
    tbl.push_back(mk("ld_and_br", 1,  2,  2, 0, 0, 1, 0, 0, 1, 0, 4'b0010));
    tbl.push_back(mk("tail",      0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 4'b1100));
    foreach (tbl[i]) step(tbl[i], 1'b0);
    check("a_stallcnt_sat", 32'(ifa.StallCnt), 32'd3);
    check("a_flushcnt", 32'(ifa.FlushCnt), 32'd1);

    // Clear coinciding with a stall: clear wins.
    step(mk("clr_ld", 1, 2, 2, 0, 0, 1, 0, 0, 0, 1, 4'b0010), 1'b0);
    step(idle, 1'b0);
    check("a_clr_stall", 32'(ifa.StallCnt), 32'd0);
    check("a_clr_flush", 32'(ifa.FlushCnt), 32'd0);

    // Three-cycle load stall via Rd source; inputs drop after the first cycle.
    step(mk("t3_c1", 1, 5, 0, 0, 5, 0, 0, 1, 0, 0, 4'b0010), 1'b1);
    step(mk("t3_c2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010), 1'b1);
    step(mk("t3_c3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010), 1'b1);
    step(mk("t3_c4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100), 1'b1);
    check("t3_stallcnt", 32'(ifb.StallCnt), 32'd3);

    // Two-cycle flush; a second branch in cycle 2 is ignored.
    step(mk("t4_c1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1101), 1'b1);
    step(mk("t4_c2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1101), 1'b1);
    step(mk("t4_c3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100), 1'b1);
    check("t4_flushcnt", 32'(ifb.FlushCnt), 32'd2);

    // Reset during stall cycle 2 of 3, with the hazard inputs still matching.
    step(mk("t6_c1", 1, 4, 4, 0, 0, 1, 0, 0, 0, 0, 4'b0010), 1'b1);
    @(posedge clk);
    #1;
    drive(mk("t6_c2", 1, 4, 4, 0, 0, 1, 0, 0, 0, 0, 4'b0010), 1'b1);
    check("t6_pre_rst", 32'(outs(1'b1)), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_out", 32'(outs(1'b1)), 32'hC);
    check("t6_rst_cnt", {ifb.StallCnt, ifb.FlushCnt}, 32'd0);
    @(negedge clk);
    drive(idle, 1'b1);
    reset = 1'b0;
    step(mk("t6_post", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100), 1'b1);
    step(mk("t6_post2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100), 1'b1);
    check("t6_stallcnt", 32'(ifb.StallCnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
